// File: rtl/glb_port_arbiter.sv
// Two-port round-robin arbiter for the single GLB read/write port (port 0 = tiling
// engine, port 1 = pass controller). Optional performance counters: GLB_ARB_PERF_EN.
module glb_port_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [3:0]           we0,
  input  logic [3:0]           we1,
  input  logic [ADDR_BITS-1:0] waddr0,
  input  logic [ADDR_BITS-1:0] waddr1,
  input  logic [DATA_SIZE-1:0] wdata0,
  input  logic [DATA_SIZE-1:0] wdata1,
  input  logic [3:0]           re0,
  input  logic [3:0]           re1,
  input  logic [ADDR_BITS-1:0] raddr0,
  input  logic [ADDR_BITS-1:0] raddr1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATA_SIZE-1:0] rdata,
  output logic [3:0]           glb_we,
  output logic [ADDR_BITS-1:0] glb_w_addr,
  output logic [DATA_SIZE-1:0] glb_din,
  output logic [3:0]           glb_re,
  output logic [ADDR_BITS-1:0] glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_dout
`ifdef GLB_ARB_PERF_EN
  ,
  output logic [31:0]          wait_cyc0,
  output logic [31:0]          wait_cyc1,
  output logic [31:0]          xfer_cyc0,
  output logic [31:0]          xfer_cyc1
`endif
);

  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             last_q, last_d;
  logic             rvalid0_q, rvalid1_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                                       state_d = req1 ? OWN1 : IDLE;
        else if (req1 && (burst_q == CNT_MAX) && !lock0) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                                       state_d = req0 ? OWN0 : IDLE;
        else if (req0 && (burst_q == CNT_MAX) && !lock1) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst count keeps running with no contender so the cap bites the moment one appears.
  always_comb begin
    burst_d = burst_q;
    if (state_d != state_q)                           burst_d = '0;
    else if ((state_q != IDLE) && (burst_q != CNT_MAX)) burst_d = burst_q + 1'b1;
  end

  always_comb begin
    last_d = last_q;
    if ((state_d == OWN0) && (state_q != OWN0)) last_d = 1'b0;
    if ((state_d == OWN1) && (state_q != OWN1)) last_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      rvalid0_q <= (state_q == OWN0) && (|re0);
      rvalid1_q <= (state_q == OWN1) && (|re1);
    end
  end

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = glb_dout;

  // Non-owner strobes never reach the GLB; idle drives all zeros.
  always_comb begin
    glb_we     = '0;
    glb_w_addr = '0;
    glb_din    = '0;
    glb_re     = '0;
    glb_r_addr = '0;
    case (state_q)
      OWN0: begin
        glb_we     = we0;
        glb_w_addr = waddr0;
        glb_din    = wdata0;
        glb_re     = re0;
        glb_r_addr = raddr0;
      end
      OWN1: begin
        glb_we     = we1;
        glb_w_addr = waddr1;
        glb_din    = wdata1;
        glb_re     = re1;
        glb_r_addr = raddr1;
      end
      default: ;
    endcase
  end

`ifdef GLB_ARB_PERF_EN
  logic [31:0] wait0_q, wait1_q, xfer0_q, xfer1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait0_q <= '0;
      wait1_q <= '0;
      xfer0_q <= '0;
      xfer1_q <= '0;
    end else begin
      if (req0 && !gnt0 && (wait0_q != 32'hFFFF_FFFF)) wait0_q <= wait0_q + 32'd1;
      if (req1 && !gnt1 && (wait1_q != 32'hFFFF_FFFF)) wait1_q <= wait1_q + 32'd1;
      if (gnt0 && ((|we0) || (|re0)) && (xfer0_q != 32'hFFFF_FFFF)) xfer0_q <= xfer0_q + 32'd1;
      if (gnt1 && ((|we1) || (|re1)) && (xfer1_q != 32'hFFFF_FFFF)) xfer1_q <= xfer1_q + 32'd1;
    end
  end

  assign wait_cyc0 = wait0_q;
  assign wait_cyc1 = wait1_q;
  assign xfer_cyc0 = xfer0_q;
  assign xfer_cyc1 = xfer1_q;
`endif

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Bench for glb_port_arbiter: directed scenarios plus randomized traffic compared
// every cycle against a transaction-level owner/memory model.
module tb_glb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0, req1, lock0, lock1;
  logic [3:0]    we0, we1, re0, re1;
  logic [AW-1:0] waddr0, waddr1, raddr0, raddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [3:0]    glb_we, glb_re;
  logic [AW-1:0] glb_w_addr, glb_r_addr;
  logic [DW-1:0] glb_din;
  logic [DW-1:0] glb_dout = '0;

  glb_port_arbiter #(.DATA_SIZE(DW), .ADDR_BITS(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .re0(re0), .re1(re1), .raddr0(raddr0), .raddr1(raddr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_din(glb_din),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_dout(glb_dout)
  );

  always #5 clk = ~clk;

  // GLB stand-in: 64 words, write-first, one-cycle read latency.
  logic [DW-1:0] glb_mem [64] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (glb_we[b]) glb_mem[glb_w_addr[7:2]][8*b +: 8] = glb_din[8*b +: 8];
    if (|glb_re) glb_dout <= glb_mem[glb_r_addr[7:2]];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: who owns the port, how long it has held it, who won last.
  int            owner;
  int            last;
  int            held;
  bit            pend [2];
  logic [DW-1:0] pend_data [2];
  logic [DW-1:0] mdl_mem [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1; held = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  task automatic compare();
    logic [3:0]    e_we, e_re;
    logic [AW-1:0] e_wa, e_ra;
    logic [DW-1:0] e_wd;
    if (rst) model_reset();
    e_we = '0; e_re = '0; e_wa = '0; e_ra = '0; e_wd = '0;
    if (owner == 0) begin
      e_we = we0; e_re = re0; e_wa = waddr0; e_ra = raddr0; e_wd = wdata0;
    end else if (owner == 1) begin
      e_we = we1; e_re = re1; e_wa = waddr1; e_ra = raddr1; e_wd = wdata1;
    end
    chk("gnt0", gnt0, owner == 0);
    chk("gnt1", gnt1, owner == 1);
    chk("rvalid0", rvalid0, pend[0]);
    chk("rvalid1", rvalid1, pend[1]);
    chk("glb_we", glb_we, e_we);
    chk("glb_re", glb_re, e_re);
    chk("glb_w_addr", glb_w_addr, e_wa);
    chk("glb_r_addr", glb_r_addr, e_ra);
    chk("glb_din", glb_din, e_wd);
    if (pend[0]) chk("rdata0", rdata, pend_data[0]);
    if (pend[1]) chk("rdata1", rdata, pend_data[1]);
  endtask

  task automatic model_step();
    logic [3:0]    we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    bit            rq [2];
    bit            lk [2];
    int            nxt;
    if (rst) return;
    rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    if (owner >= 0) begin
      we = (owner == 0) ? we0 : we1;
      re = (owner == 0) ? re0 : re1;
      wa = (owner == 0) ? waddr0 : waddr1;
      ra = (owner == 0) ? raddr0 : raddr1;
      wd = (owner == 0) ? wdata0 : wdata1;
      for (int b = 0; b < 4; b++)
        if (we[b]) mdl_mem[wa[7:2]][8*b +: 8] = wd[8*b +: 8];
      if (|re) begin
        pend[owner]      = 1'b1;
        pend_data[owner] = mdl_mem[ra[7:2]];
      end
    end
    nxt = owner;
    if (owner < 0) begin
      if (rq[0] && rq[1]) nxt = 1 - last;
      else if (rq[0])     nxt = 0;
      else if (rq[1])     nxt = 1;
    end else if (!rq[owner]) begin
      nxt = rq[1-owner] ? 1 - owner : -1;
    end else if (rq[1-owner] && (held + 1 >= MB) && !lk[owner]) begin
      nxt = 1 - owner;
    end
    if (nxt != owner) begin
      held = 0;
      if (nxt >= 0) last = nxt;
    end else if (owner >= 0) begin
      held++;
    end
    owner = nxt;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    we0 = '0; we1 = '0; re0 = '0; re1 = '0;
    waddr0 = '0; waddr1 = '0; raddr0 = '0; raddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    clr_inputs();
    model_reset();
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;

    // Reset state
    do_reset();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_glb_we", glb_we, 0);

    // Lone requester; port 1 write strobes while not owner
    req0 = 1;
    cycle();
    chk("t1_gnt0", gnt0, 1);
    we0 = 4'hF; waddr0 = 32'h40; wdata0 = 32'hDEAD_BEEF;
    we1 = 4'hF; waddr1 = 32'h40; wdata1 = 32'h0;
    cycle();
    we0 = '0;
    cycle();
    chk("t1_mem40", glb_mem[16], 32'hDEAD_BEEF);
    chk("t1_gnt1", gnt1, 0);

    // Contention: burst cap hands over after MB cycles, read on last cycle returns
    do_reset();
    req0 = 1; req1 = 1;
    cycle();
    n = 0;
    while (gnt0 && n < 40) begin
      n++;
      if (n == MB) begin re0 = 4'hF; raddr0 = 32'h40; end
      cycle();
      re0 = '0;
    end
    chk("t2_burst_len", n, MB);
    chk("t2_gnt1", gnt1, 1);
    chk("t4_rvalid0", rvalid0, 1);
    chk("t4_rvalid1", rvalid1, 0);
    chk("t4_rdata", rdata, 32'hDEAD_BEEF);

    // Lock holds the grant past the cap
    do_reset();
    req1 = 1; lock1 = 1;
    cycle();
    req0 = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (gnt1) n++;
      cycle();
    end
    chk("t3_locked_len", n, 40);
    req1 = 0; lock1 = 0;
    cycle();
    chk("t3_gnt0", gnt0, 1);

    // Async reset mid-burst
    do_reset();
    req1 = 1;
    cycle();
    re1 = 4'hF; raddr1 = 32'h40;
    cycle();
    cycle();
    chk("t6_rvalid1_pre", rvalid1, 1);
    rst = 1'b1;
    #1;
    chk("t6_gnt1", gnt1, 0);
    chk("t6_rvalid1", rvalid1, 0);
    clr_inputs();
    cycle();
    rst = 1'b0;
    req0 = 1; req1 = 1;
    cycle();
    chk("t6_gnt0_first", gnt0, 1);
    chk("t6_gnt1_wait", gnt1, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)   req0 = ~req0;
      if ($urandom_range(0, 7) == 0)   req1 = ~req1;
      if ($urandom_range(0, 15) == 0)  lock0 = ~lock0;
      if ($urandom_range(0, 15) == 0)  lock1 = ~lock1;
      we0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      we1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      re0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      re1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      waddr0 = {24'h0, 6'($urandom), 2'b00};
      waddr1 = {24'h0, 6'($urandom), 2'b00};
      raddr0 = {24'h0, 6'($urandom), 2'b00};
      raddr1 = {24'h0, 6'($urandom), 2'b00};
      wdata0 = $urandom;
      wdata1 = $urandom;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      else                             rst = 1'b0;
      cycle();
    end
    rst = 1'b0;
    clr_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
